// File: rtl/nes_pad_reader_if.sv
// Parallel-side and pad-side signals of the serial game-pad reader.
// The slave modport is the reader itself; master is the host/pad side.
interface nes_pad_reader_if;
  logic       poll_req;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] controller_data;
  logic       data_valid;
  logic       busy;

  modport slave (
    input  poll_req,
    input  pad_data,
    output pad_latch,
    output pad_clk,
    output controller_data,
    output data_valid,
    output busy
  );

  modport master (
    output poll_req,
    output pad_data,
    input  pad_latch,
    input  pad_clk,
    input  controller_data,
    input  data_valid,
    input  busy
  );
endinterface

// File: rtl/nes_pad_reader.sv
// Serial game-pad reader: latches the pad, clocks out 8 active-low buttons, presents them active-high.
// Optional per-bit two-poll agreement filter is built when NES_PAD_DEBOUNCE_EN is defined.
module nes_pad_reader #(
  parameter int unsigned CLK_DIV     = 300,
  parameter int unsigned POLL_PERIOD = 833333,
  parameter int unsigned CNT_W       = 20
) (
  input  logic             clk,
  input  logic             reset,
  nes_pad_reader_if.slave  bus
);

  localparam int unsigned PH_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [PH_W-1:0]  LATCH_LOAD = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  HALF_LOAD  = PH_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX  = CNT_W'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETTLE,
    S_CLK_LO,
    S_CLK_HI,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       sample_q, sample_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       data_q, data_d;
  logic             timer_wrap;
  logic             phase_last;
  logic             publish;

  // Free-running poll timer; it keeps counting while a poll is in flight.
  assign timer_wrap = (timer_q == TIMER_MAX);
  assign timer_d    = timer_wrap ? '0 : timer_q + CNT_W'(1);
  assign phase_last = (phase_q == '0);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    bit_idx_d      = bit_idx_q;
    sample_d       = sample_q;
    pending_d      = pending_q | timer_wrap | bus.poll_req;
    publish        = 1'b0;
    bus.pad_latch  = 1'b0;
    bus.pad_clk    = 1'b1;
    bus.data_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Consuming pending swallows any trigger landing in this same cycle.
        if (pending_q) begin
          pending_d = 1'b0;
          phase_d   = LATCH_LOAD;
          state_d   = S_LATCH;
        end
      end

      S_LATCH: begin
        bus.pad_latch = 1'b1;
        if (phase_last) begin
          phase_d = HALF_LOAD;
          state_d = S_SETTLE;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end

      S_SETTLE: begin
        if (phase_last) begin
          sample_d[0] = ~bus.pad_data;
          bit_idx_d   = 3'd1;
          phase_d     = HALF_LOAD;
          state_d     = S_CLK_LO;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end

      S_CLK_LO: begin
        bus.pad_clk = 1'b0;
        if (phase_last) begin
          phase_d = HALF_LOAD;
          state_d = S_CLK_HI;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end

      S_CLK_HI: begin
        if (phase_last) begin
          sample_d[bit_idx_q] = ~bus.pad_data;
          if (bit_idx_q == 3'd7) begin
            // Publish on the edge into DONE so data and data_valid appear together.
            publish = 1'b1;
            state_d = S_DONE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            phase_d   = HALF_LOAD;
            state_d   = S_CLK_LO;
          end
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end

      S_DONE: begin
        bus.data_valid = 1'b1;
        state_d        = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef NES_PAD_DEBOUNCE_EN
  logic [7:0] prev_q;
  logic [7:0] agree;

  // A bit follows the pad only once two consecutive raw samples agree on it.
  assign agree  = ~(sample_d ^ prev_q);
  assign data_d = (data_q & ~agree) | (sample_d & agree);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
    end else if (publish) begin
      prev_q <= sample_d;
    end
  end
`else
  assign data_d = sample_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      bit_idx_q <= '0;
      sample_q  <= '0;
      pending_q <= 1'b0;
      timer_q   <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      sample_q  <= sample_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      if (publish) begin
        data_q <= data_d;
      end
    end
  end

  assign bus.controller_data = data_q;
  assign bus.busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a behavioural pad (parallel-in, serial-out shift register).
module tb_nes_pad_reader;

  localparam int CLK_DIV     = 4;
  localparam int POLL_PERIOD = 100;

`ifdef NES_PAD_DEBOUNCE_EN
  localparam logic [7:0] EXP_A5   = 8'h00;
  localparam logic [7:0] EXP_5A_1 = 8'h00;
  localparam logic [7:0] EXP_5A_2 = 8'h5A;
  localparam logic [7:0] EXP_3C   = 8'h00;
  localparam logic [7:0] EXP_HI   = 8'h00;
  localparam logic [7:0] EXP_LO   = 8'h00;
  localparam logic [7:0] EXP_D1   = 8'h00;
  localparam logic [7:0] EXP_D2   = 8'h0F;
  localparam logic [7:0] EXP_D3   = 8'h0F;
`else
  localparam logic [7:0] EXP_A5   = 8'hA5;
  localparam logic [7:0] EXP_5A_1 = 8'h5A;
  localparam logic [7:0] EXP_5A_2 = 8'h5A;
  localparam logic [7:0] EXP_3C   = 8'h3C;
  localparam logic [7:0] EXP_HI   = 8'h00;
  localparam logic [7:0] EXP_LO   = 8'hFF;
  localparam logic [7:0] EXP_D1   = 8'hFF;
  localparam logic [7:0] EXP_D2   = 8'h0F;
  localparam logic [7:0] EXP_D3   = 8'h0F;
`endif

  logic clk = 1'b0;
  logic reset;

  nes_pad_reader_if pif ();

  nes_pad_reader #(
    .CLK_DIV     (CLK_DIV),
    .POLL_PERIOD (POLL_PERIOD),
    .CNT_W       (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pif)
  );

  always #5 clk = ~clk;

  // Pad model: loads while latch is high, shifts toward bit 0 on each pad_clk rise.
  logic [7:0] buttons  = 8'h00;
  logic [7:0] pad_sr   = 8'h00;
  logic       pad_clk_prev = 1'b1;
  logic       hold_en  = 1'b0;
  logic       hold_val = 1'b1;

  always @(posedge clk) begin
    pad_clk_prev <= pif.pad_clk;
    if (pif.pad_latch) begin
      pad_sr <= buttons;
    end else if (pif.pad_clk && !pad_clk_prev) begin
      pad_sr <= {1'b0, pad_sr[7:1]};
    end
  end

  assign pif.pad_data = hold_en ? hold_val : ~pad_sr[0];

  int checks = 0;
  int errors = 0;

  int cyc;
  int dv_count, dv_first_cyc, dv_cyc;
  int latch_rises, latch_first, latch_cnt;
  int lo_pulses, lo_bad, lo_len, overlap, unstable;
  logic [7:0] dv_first_data, dv_data, prev_cd;
  logic       prev_latch;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic clear_stats();
    dv_count = 0; dv_first_cyc = 0; dv_cyc = 0;
    latch_rises = 0; latch_first = 0; latch_cnt = 0;
    lo_pulses = 0; lo_bad = 0; lo_len = 0; overlap = 0; unstable = 0;
    dv_first_data = 8'h00; dv_data = 8'h00; prev_cd = 8'h00; prev_latch = 1'b0;
  endtask

  // Advance one cycle and observe outputs mid-cycle.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (pif.data_valid === 1'b1) begin
      dv_count++;
      if (dv_count == 1) begin
        dv_first_cyc  = cyc;
        dv_first_data = pif.controller_data;
      end
      dv_cyc  = cyc;
      dv_data = pif.controller_data;
    end else if (pif.controller_data !== prev_cd) begin
      unstable++;
    end
    prev_cd = pif.controller_data;
    if (pif.pad_latch === 1'b1) begin
      latch_cnt++;
      if (!prev_latch) begin
        latch_rises++;
        latch_first = cyc;
      end
    end
    prev_latch = pif.pad_latch;
    if (pif.pad_clk === 1'b0) begin
      lo_len++;
      if (pif.pad_latch === 1'b1) overlap++;
    end else if (lo_len != 0) begin
      lo_pulses++;
      if (lo_len != CLK_DIV) lo_bad++;
      lo_len = 0;
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic pulse_req();
    pif.poll_req = 1'b1;
    tick();
    pif.poll_req = 1'b0;
  endtask

  task automatic wait_dv(input string tag, input int budget);
    int start;
    int n;
    start = dv_count;
    n = 0;
    while (dv_count == start && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("%s dv seen", tag), 32'(dv_count != start), 32'd1);
  endtask

  // Called at a falling edge: release reset there and restart cycle numbering.
  task automatic release_reset();
    reset = 1'b1;
    cyc = 0;
    clear_stats();
  endtask

  int dv_before;

  initial begin
    pif.poll_req = 1'b0;
    buttons = 8'hA5;
    clear_stats();
    cyc = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);

    check("rst controller_data", 32'(pif.controller_data), 32'h00);
    check("rst pad_clk",         32'(pif.pad_clk),         32'd1);
    check("rst pad_latch",       32'(pif.pad_latch),       32'd0);
    check("rst data_valid",      32'(pif.data_valid),      32'd0);
    check("rst busy",            32'(pif.busy),            32'd0);
    release_reset();

    // First automatic poll: wrap in cycle 99, consumed in 100.
    run_to(99);
    check("p1 no early latch", 32'(latch_rises), 32'd0);
    wait_dv("p1", 200);
    check("p1 latch rise cycle", 32'(latch_first), 32'd101);
    check("p1 latch length",     32'(latch_cnt),   32'd8);
    check("p1 dv cycle",         32'(dv_cyc),      32'd169);
    check("p1 data",             32'(dv_data),     32'(EXP_A5));
    check("p1 clk low pulses",   32'(lo_pulses),   32'd7);
    check("p1 pulse widths",     32'(lo_bad),      32'd0);
    check("p1 clk low in latch", 32'(overlap),     32'd0);
    tick();
    check("p1 dv single cycle",  32'(pif.data_valid),      32'd0);
    check("p1 busy cleared",     32'(pif.busy),            32'd0);
    check("p1 data held",        32'(pif.controller_data), 32'(EXP_A5));

    // Coalescing: request at 40, wrap at 99 and requests inside the poll yield one extra poll.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    buttons = 8'h5A;
    release_reset();
    run_to(40);
    pulse_req();
    run_to(42);
    check("req latch starts",    32'(pif.pad_latch), 32'd1);
    check("req latch cycle",     32'(latch_first),   32'd42);
    run_to(60);  pulse_req();
    run_to(80);  pulse_req();
    run_to(100); pulse_req();
    run_to(110);
    check("req dv cycle",        32'(dv_first_cyc),  32'd110);
    check("req data",            32'(dv_first_data), 32'(EXP_5A_1));
    run_to(111);
    pulse_req();
    check("extra latch cycle",   32'(latch_first),   32'd112);
    run_to(180);
    check("extra dv count",      32'(dv_count),      32'd2);
    check("extra dv cycle",      32'(dv_cyc),        32'd180);
    check("extra data",          32'(dv_data),       32'(EXP_5A_2));
    run_to(199);
    check("no third poll dv",    32'(dv_count),      32'd2);
    check("no third poll latch", 32'(latch_rises),   32'd2);
    check("idle before wrap",    32'(pif.busy),      32'd0);
    run_to(201);
    check("wrap poll latch",     32'(latch_first),   32'd201);

    // Abandon the wrap poll in CLK_HI of bit 4.
    run_to(242);
    check("bit4 pad_clk high",   32'(pif.pad_clk),   32'd1);
    check("bit4 busy",           32'(pif.busy),      32'd1);
    check("bit4 pulses so far",  32'(lo_pulses),     32'd18);
    reset = 1'b0;
    #1;
    check("midpoll rst data",      32'(pif.controller_data), 32'h00);
    check("midpoll rst pad_clk",   32'(pif.pad_clk),         32'd1);
    check("midpoll rst pad_latch", 32'(pif.pad_latch),       32'd0);
    check("midpoll rst dv",        32'(pif.data_valid),      32'd0);
    check("midpoll rst busy",      32'(pif.busy),            32'd0);
    prev_cd = 8'h00;
    dv_before = dv_count;
    repeat (3) tick();
    check("midpoll no dv",       32'(dv_count),      32'(dv_before));
    buttons = 8'h3C;
    release_reset();
    wait_dv("post-rst", 200);
    check("post-rst latch cycle", 32'(latch_first),  32'd101);
    check("post-rst dv cycle",    32'(dv_cyc),       32'd169);
    check("post-rst dv count",    32'(dv_count),     32'd1);
    check("post-rst data",        32'(dv_data),      32'(EXP_3C));

    // Pad data line held at constant levels.
    hold_en  = 1'b1;
    hold_val = 1'b1;
    wait_dv("held high", 150);
    check("held high dv cycle",  32'(dv_cyc),  32'd269);
    check("held high data",      32'(dv_data), 32'(EXP_HI));
    hold_val = 1'b0;
    wait_dv("held low", 150);
    check("held low dv cycle",   32'(dv_cyc),  32'd369);
    check("held low data",       32'(dv_data), 32'(EXP_LO));
    check("data only changes on dv", 32'(unstable), 32'd0);
    check("all pulse widths",    32'(lo_bad),  32'd0);
    check("never low in latch",  32'(overlap), 32'd0);
    hold_en = 1'b0;

    // Sample sequence FF, 0F, 0F from a clean reset.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    buttons = 8'hFF;
    release_reset();
    wait_dv("seq1", 200);
    check("seq1 data", 32'(dv_data), 32'(EXP_D1));
    buttons = 8'h0F;
    wait_dv("seq2", 150);
    check("seq2 data", 32'(dv_data), 32'(EXP_D2));
    wait_dv("seq3", 150);
    check("seq3 data", 32'(dv_data), 32'(EXP_D3));
    check("seq dv count", 32'(dv_count), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Serial game-pad front end that produces the parallel `controller_data[7:0]` bus the processor samples as a memory-mapped input.
- Drives the pad's latch and clock lines and shifts in 8 active-low button bits.
- Presents them to the processor active-high and holds them stable between polls.
- Polls autonomously at a fixed rate, or on request.

Parameters:
- CLK_DIV, 300, system cycles per pad-clock half period and per latch unit (6 us at 50 MHz); legal range ≥1.
- POLL_PERIOD, 833333, system cycles between automatic polls (60 Hz at 50 MHz); legal range ≥ 17*CLK_DIV+2.
- CNT_W, 20, width of the poll timer; must hold POLL_PERIOD-1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- poll_req  in  1  one-cycle request for an immediate poll.
- pad_data  in  1  serial data from the pad; low = button pressed; pre-synchronised externally.
- pad_latch  out  1  pad parallel-load strobe, active-high.
- pad_clk  out  1  pad shift clock; idles high; the pad shifts on the rising edge.
- controller_data  out  8  button state, 1 = pressed. Bit map: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- data_valid  out  1  one-cycle pulse when controller_data is updated.
- busy  out  1  high while a poll is in progress (any state except IDLE).

Behaviour:
- Reset (reset=0, asynchronous), all immediate:
  - state=IDLE, pad_latch=0, pad_clk=1, controller_data=8'h00, data_valid=0, busy=0.
  - Poll timer=0, pending=0, shift register=0.
- Reset mid-poll: the poll is abandoned. No data_valid pulse is produced and controller_data is cleared to 0.
- Poll timer:
  - Counts 0..POLL_PERIOD-1 every cycle, including during polls, then wraps to 0.
  - The wrap cycle sets pending.
  - poll_req=1 also sets pending.
  - Any number of triggers before a poll starts coalesce into one poll.
- States:
  - IDLE:
    - pad_latch=0, pad_clk=1.
    - If pending=1: clear pending, load the phase counter, go to LATCH.
    - A trigger arriving in the same cycle that pending is consumed is also coalesced; it does not queue a second poll.
  - LATCH: pad_latch=1 for 2*CLK_DIV cycles, then go to SETTLE.
  - SETTLE:
    - pad_latch=0, pad_clk=1 for CLK_DIV cycles.
    - On the last cycle, sample ~pad_data into bit 0.
    - Go to CLK_LO with bit index=1.
  - CLK_LO: pad_clk=0 for CLK_DIV cycles, then go to CLK_HI.
  - CLK_HI:
    - pad_clk=1 for CLK_DIV cycles.
    - On the last cycle, sample ~pad_data into the bit at the current index.
    - If index=7, go to DONE; otherwise increment index and go to CLK_LO.
  - DONE (1 cycle):
    - controller_data ← all 8 sampled bits at once; data_valid=1.
    - Go to IDLE.
- Latency: if pending is consumed in IDLE at cycle T, then:
  - pad_latch is high in cycles T+1 .. T+2*CLK_DIV.
  - data_valid is high in exactly cycle T+17*CLK_DIV+1.
- Pulse count: exactly 7 pad_clk low pulses per poll; pad_clk never goes low while pad_latch=1.
- Stability: controller_data never shows partial data; it changes only in DONE or on reset.
- Triggers during a poll set pending. That starts exactly one further poll from IDLE on the cycle after DONE.
- poll_req is accepted regardless of busy; it is never dropped, only coalesced.

Optional Feature:
- Macro: NES_PAD_DEBOUNCE_EN.
- Defined:
  - DONE compares the new 8-bit sample with the previous poll's raw sample.
  - Each bit of controller_data updates only if the new and previous samples agree; otherwise that bit keeps its old value.
  - data_valid still pulses every DONE.
  - The previous-sample register resets to 0.
- Undefined: controller_data takes each sample directly. The previous-sample register is not built.

Test Plan (CLK_DIV=4, POLL_PERIOD=100 unless noted):
- Reset release → controller_data=00, pad_clk=1, pad_latch=0. The first automatic poll starts when the timer wraps (cycle 99 after release); pad_latch is high for 8 cycles.
- pad_data model presents 8'hA5 active-low (bit0 first, shifted on pad_clk rising edge) → data_valid once, exactly 69 cycles after trigger consumption; controller_data=8'hA5; 7 pad_clk low pulses, each 4 cycles.
- poll_req pulsed 3 times during a poll plus a timer wrap → exactly one extra poll, starting the cycle after DONE; no third poll until the next wrap.
- reset asserted in CLK_HI of bit 4 → outputs reach reset values immediately; no data_valid; after release the next poll returns correct data (8'h3C).
- pad_data held high (no buttons) → controller_data=00; held low → 8'hFF.
- NES_PAD_DEBOUNCE_EN defined: samples FF, 0F, 0F across three polls → controller_data 00, 0F, 0F. Undefined: FF, 0F, 0F.
